// File: rtl/cv32e40p_recovery_sequencer.sv
// Rollback sequencer for cv32e40p: holds the core in setback, replays a checkpointed
// register file through the two recovery write ports, then pulses PC/CSR recovery.
module cv32e40p_recovery_sequencer #(
    parameter int NUM_REGS       = 32,
    parameter int SETBACK_CYCLES = 2,
    parameter int ADDR_WIDTH     = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  ckpt_valid_i,
    output logic [ADDR_WIDTH-1:0] ckpt_raddr_a_o,
    output logic [ADDR_WIDTH-1:0] ckpt_raddr_b_o,
    input  logic [31:0]           ckpt_rdata_a_i,
    input  logic [31:0]           ckpt_rdata_b_i,
    output logic                  setback_o,
    output logic                  recover_o,
    output logic                  regfile_we_a_o,
    output logic [ADDR_WIDTH-1:0] regfile_waddr_a_o,
    output logic [31:0]           regfile_wdata_a_o,
    output logic                  regfile_we_b_o,
    output logic [ADDR_WIDTH-1:0] regfile_waddr_b_o,
    output logic [31:0]           regfile_wdata_b_o,
    output logic                  pc_recover_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  overrun_o
);

    localparam int PAIRS    = NUM_REGS / 2;
    localparam int CNT_MAX  = (SETBACK_CYCLES > PAIRS) ? SETBACK_CYCLES : PAIRS;
    localparam int CNT_BITS = $clog2(CNT_MAX + 1);
    localparam int CNT_W    = (CNT_BITS > ADDR_WIDTH) ? CNT_BITS : ADDR_WIDTH;

    localparam logic [CNT_W-1:0] HALT_LAST = CNT_W'(SETBACK_CYCLES - 1);
    // RF_RESTORE runs one extra cycle (count == PAIRS) to drain the last write.
    localparam logic [CNT_W-1:0] RF_LAST   = CNT_W'(PAIRS);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HALT       = 3'd1,
        ST_RF_RESTORE = 3'd2,
        ST_PC_RESTORE = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_s;
    logic                  error_s;
    logic                  overrun_s;
    logic                  busy_s;
    logic                  issue_s;
    logic                  we_s;
    logic [ADDR_WIDTH-1:0] raddr_a_s;
    logic [ADDR_WIDTH-1:0] raddr_b_s;
    logic [ADDR_WIDTH-1:0] waddr_a_s;
    logic [ADDR_WIDTH-1:0] waddr_b_s;

    function automatic logic [ADDR_WIDTH-1:0] pair_addr(input logic [CNT_W-1:0] pair,
                                                        input logic odd);
        return {pair[ADDR_WIDTH-2:0], odd};
    endfunction

    // Next-state and counter sequencing.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        error_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    if (ckpt_valid_i) begin
                        state_s = ST_HALT;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                        error_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (cnt_r == HALT_LAST) begin
                    state_s = ST_RF_RESTORE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RF_RESTORE: begin
                if (cnt_r == RF_LAST) begin
                    state_s = ST_PC_RESTORE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_PC_RESTORE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output pre-decode: read issue follows the next state, the write stage trails one cycle.
    always_comb begin
        busy_s  = (state_s == ST_HALT) || (state_s == ST_RF_RESTORE) || (state_s == ST_PC_RESTORE);
        issue_s = (state_s == ST_RF_RESTORE) && (cnt_s != RF_LAST);
        we_s    = (state_r == ST_RF_RESTORE) && (cnt_r != RF_LAST);
        if (issue_s) begin
            raddr_a_s = pair_addr(cnt_s, 1'b0);
            raddr_b_s = pair_addr(cnt_s, 1'b1);
        end else begin
            raddr_a_s = {ADDR_WIDTH{1'b0}};
            raddr_b_s = {ADDR_WIDTH{1'b0}};
        end
        if (we_s) begin
            waddr_a_s = pair_addr(cnt_r, 1'b0);
            waddr_b_s = pair_addr(cnt_r, 1'b1);
        end else begin
            waddr_a_s = {ADDR_WIDTH{1'b0}};
            waddr_b_s = {ADDR_WIDTH{1'b0}};
        end
        if (start_i && busy_o) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_o;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r           <= ST_IDLE;
            cnt_r             <= {CNT_W{1'b0}};
            ckpt_raddr_a_o    <= {ADDR_WIDTH{1'b0}};
            ckpt_raddr_b_o    <= {ADDR_WIDTH{1'b0}};
            setback_o         <= 1'b0;
            recover_o         <= 1'b0;
            regfile_we_a_o    <= 1'b0;
            regfile_waddr_a_o <= {ADDR_WIDTH{1'b0}};
            regfile_we_b_o    <= 1'b0;
            regfile_waddr_b_o <= {ADDR_WIDTH{1'b0}};
            pc_recover_o      <= 1'b0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            error_o           <= 1'b0;
            overrun_o         <= 1'b0;
        end else begin
            state_r           <= state_s;
            cnt_r             <= cnt_s;
            ckpt_raddr_a_o    <= raddr_a_s;
            ckpt_raddr_b_o    <= raddr_b_s;
            setback_o         <= (state_s == ST_HALT);
            recover_o         <= busy_s;
            regfile_we_a_o    <= we_s;
            regfile_waddr_a_o <= waddr_a_s;
            regfile_we_b_o    <= we_s;
            regfile_waddr_b_o <= waddr_b_s;
            pc_recover_o      <= (state_s == ST_PC_RESTORE);
            busy_o            <= busy_s;
            done_o            <= (state_s == ST_DONE);
            error_o           <= error_s;
            overrun_o         <= overrun_s;
        end
    end

    // Checkpoint data arrives one cycle after its address, i.e. in the write cycle itself.
    assign regfile_wdata_a_o = regfile_we_a_o ? ckpt_rdata_a_i : 32'h0000_0000;
    assign regfile_wdata_b_o = regfile_we_b_o ? ckpt_rdata_b_i : 32'h0000_0000;

endmodule

// File: tb/tb_cv32e40p_recovery_sequencer.sv
// Directed bench: default instance (32 regs, 2 setback cycles) and a 64-reg / 1-cycle instance,
// each with a one-cycle-latency checkpoint store and a core register-file model.
module tb_cv32e40p_recovery_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    logic [5:0]  ra_a0, ra_b0, wa_a0, wa_b0, ra_a1, ra_b1, wa_a1, wa_b1;
    logic [31:0] rd_a0, rd_b0, wd_a0, wd_b0, rd_a1, rd_b1, wd_a1, wd_b1;
    logic        sb0, rec0, we_a0, we_b0, pcr0, busy0, done0, err0, ovr0;
    logic        sb1, rec1, we_a1, we_b1, pcr1, busy1, done1, err1, ovr1;
    logic [31:0] rf0 [0:31];
    logic [31:0] rf1 [0:63];

    always #5 clk = ~clk;

    cv32e40p_recovery_sequencer dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .ckpt_valid_i(valid),
        .ckpt_raddr_a_o(ra_a0), .ckpt_raddr_b_o(ra_b0),
        .ckpt_rdata_a_i(rd_a0), .ckpt_rdata_b_i(rd_b0),
        .setback_o(sb0), .recover_o(rec0),
        .regfile_we_a_o(we_a0), .regfile_waddr_a_o(wa_a0), .regfile_wdata_a_o(wd_a0),
        .regfile_we_b_o(we_b0), .regfile_waddr_b_o(wa_b0), .regfile_wdata_b_o(wd_b0),
        .pc_recover_o(pcr0), .busy_o(busy0), .done_o(done0), .error_o(err0), .overrun_o(ovr0)
    );

    cv32e40p_recovery_sequencer #(.NUM_REGS(64), .SETBACK_CYCLES(1), .ADDR_WIDTH(6)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .ckpt_valid_i(valid),
        .ckpt_raddr_a_o(ra_a1), .ckpt_raddr_b_o(ra_b1),
        .ckpt_rdata_a_i(rd_a1), .ckpt_rdata_b_i(rd_b1),
        .setback_o(sb1), .recover_o(rec1),
        .regfile_we_a_o(we_a1), .regfile_waddr_a_o(wa_a1), .regfile_wdata_a_o(wd_a1),
        .regfile_we_b_o(we_b1), .regfile_waddr_b_o(wa_b1), .regfile_wdata_b_o(wd_b1),
        .pc_recover_o(pcr1), .busy_o(busy1), .done_o(done1), .error_o(err1), .overrun_o(ovr1)
    );

    function automatic logic [31:0] ck_val(input logic [5:0] a);
        return 32'hA5A5_0000 + {26'd0, a};
    endfunction

    // Checkpoint stores (registered read) and core register files.
    always @(posedge clk) begin
        rd_a0 <= ck_val(ra_a0);
        rd_b0 <= ck_val(ra_b0);
        rd_a1 <= ck_val(ra_a1);
        rd_b1 <= ck_val(ra_b1);
        if (we_a0) rf0[wa_a0[4:0]] <= wd_a0;
        if (we_b0) rf0[wa_b0[4:0]] <= wd_b0;
        if (we_a1) rf1[wa_a1] <= wd_a1;
        if (we_b1) rf1[wa_b1] <= wd_b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) start0 = v;
        else start1 = v;
    endtask

    function automatic logic [30:0] obs_ctl(input int which);
        if (which == 0)
            return {sb0, rec0, busy0, pcr0, done0, ra_a0, ra_b0, we_a0, wa_a0, we_b0, wa_b0};
        else
            return {sb1, rec1, busy1, pcr1, done1, ra_a1, ra_b1, we_a1, wa_a1, we_b1, wa_b1};
    endfunction

    function automatic logic [63:0] obs_wdata(input int which);
        if (which == 0) return {wd_a0, wd_b0};
        else return {wd_a1, wd_b1};
    endfunction

    function automatic logic [1:0] obs_flags(input int which);
        if (which == 0) return {err0, ovr0};
        else return {err1, ovr1};
    endfunction

    // Expected control outputs in cycle c of a sequence (c=0: idle).
    function automatic logic [30:0] exp_ctl(input int c, input int sb, input int nr);
        int   pc_c;
        logic s, r, p, d, rd, wr;
        logic [5:0] ra, rb, wa, wb;
        pc_c = sb + nr / 2 + 2;
        s  = (c >= 1) && (c <= sb);
        r  = (c >= 1) && (c <= pc_c);
        p  = (c == pc_c);
        d  = (c == pc_c + 1);
        rd = (c >= sb + 1) && (c <= sb + nr / 2);
        wr = (c >= sb + 2) && (c <= sb + nr / 2 + 1);
        ra = rd ? 6'(2 * (c - sb - 1)) : 6'd0;
        rb = rd ? 6'(2 * (c - sb - 1) + 1) : 6'd0;
        wa = wr ? 6'(2 * (c - sb - 2)) : 6'd0;
        wb = wr ? 6'(2 * (c - sb - 2) + 1) : 6'd0;
        return {s, r, r, p, d, ra, rb, wr, wa, wr, wb};
    endfunction

    // Caller drives start during cycle 0; this walks cycles 1.. and checks every output.
    task automatic run_seq(input int which, input int sb, input int nr,
                           input int ovr_c, input int rst_c, input bit hold_done);
        int last;
        int stop;
        int k;
        logic [31:0] ewa;
        logic [31:0] ewb;
        last = sb + nr / 2 + 3;
        stop = hold_done ? last : last + 1;
        for (int c = 1; c <= stop; c++) begin
            tick();
            set_start(which, 1'b0);
            chk($sformatf("ctl d%0d c%0d", which, c), 64'(obs_ctl(which)), 64'(exp_ctl(c, sb, nr)));
            if ((c >= sb + 2) && (c <= sb + nr / 2 + 1)) begin
                k   = c - sb - 2;
                ewa = 32'hA5A5_0000 + 32'(2 * k);
                ewb = ewa + 32'd1;
            end else begin
                ewa = 32'd0;
                ewb = 32'd0;
            end
            chk($sformatf("wdata d%0d c%0d", which, c), obs_wdata(which), {ewa, ewb});
            chk($sformatf("flags d%0d c%0d", which, c), 64'(obs_flags(which)),
                64'({1'b0, (ovr_c > 0) && (c > ovr_c)}));
            if (c == ovr_c) set_start(which, 1'b1);
            if (c == rst_c) begin
                rst = 1'b1;
                tick();
                chk($sformatf("rst ctl d%0d", which), 64'(obs_ctl(which)), 64'd0);
                chk($sformatf("rst wdata d%0d", which), obs_wdata(which), 64'd0);
                chk($sformatf("rst flags d%0d", which), 64'(obs_flags(which)), 64'd0);
                rst = 1'b0;
                return;
            end
            if (hold_done && (c == last)) set_start(which, 1'b1);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle0 %0d", i), 64'({obs_ctl(0), obs_flags(0)}), 64'd0);
            chk($sformatf("idle1 %0d", i), 64'({obs_ctl(1), obs_flags(1)}), 64'd0);
        end

        // Full default sequence.
        start0 = 1'b1;
        run_seq(0, 2, 32, 0, 0, 1'b0);
        for (int i = 0; i < 32; i++) chk($sformatf("rf0[%0d]", i), 64'(rf0[i]), 64'(ck_val(6'(i))));

        // Start rejected without a valid checkpoint.
        valid  = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("err pulse", 64'({err0, sb0, busy0}), 64'(3'b100));
        tick();
        chk("err clear", 64'({err0, sb0, busy0}), 64'(3'b000));
        valid = 1'b1;

        // Re-start in cycle 8 is ignored but latches overrun; valid drop mid-run has no effect.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        valid  = 1'b0;
        chk("busy after accept", 64'(busy0), 64'd1);
        valid  = 1'b1;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        start0 = 1'b1;
        run_seq(0, 2, 32, 8, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ovr sticky %0d", i), 64'(ovr0), 64'd1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovr cleared", 64'(ovr0), 64'd0);

        // Reset in cycle 10 aborts; restart in cycle 12 runs to completion.
        start0 = 1'b1;
        run_seq(0, 2, 32, 0, 10, 1'b0);
        tick();
        chk("post-rst idle c12", 64'({obs_ctl(0), obs_flags(0)}), 64'd0);
        start0 = 1'b1;
        run_seq(0, 2, 32, 0, 0, 1'b0);

        // 64 registers, one setback cycle; start held in DONE restarts immediately.
        start1 = 1'b1;
        run_seq(1, 1, 64, 0, 0, 1'b1);
        for (int i = 0; i < 64; i++) chk($sformatf("rf1[%0d]", i), 64'(rf1[i]), 64'(ck_val(6'(i))));
        run_seq(1, 1, 64, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
